num_acc: RTL and testbench
==========================

# num_acc

Streaming 64-bit fold unit that consumes a packet of operand beats and reduces them into one accumulator using wrap-around integer arithmetic: add, subtract and multiply, all modulo 2^64. It sits directly upstream of the plain combinational arithmetic stages. It turns a valid/ready operand stream into one result per packet. The multiply is iterative to keep the critical path to a 64x16 partial product.

## Interface
- No parameters. Data width is fixed at 64 and multiply steps at 4, both from the package.
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  synchronous reset, active-low.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block accepts a beat this cycle.
- i_op  input  2  operation: 0 LOAD, 1 PLUS, 2 MINUS, 3 MUL.
- i_data  input  64  operand, treated as unsigned (`longint unsigned`).
- i_last  input  1  final beat of the packet.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_result  output  64  accumulator value, `longint unsigned`.
- o_carry  output  1  sticky unsigned-overflow flag for the packet. Present only with NUM_ACC_CARRY_EN.

## Operation
- State machine with three states: ACC, MUL and OUT. Reset state is ACC. acc resets to 0.
- ACC state:
  - o_ready=1 and o_valid=0. A beat is accepted when i_valid is high.
  - LOAD sets acc=i_data. PLUS sets acc=acc+i_data. MINUS sets acc=acc-i_data. All wrap mod 2^64.
  - MUL latches i_data and i_last and goes to MUL.
  - Any other op with i_last=1 goes to OUT. Otherwise the block stays in ACC.
- MUL state:
  - o_ready=0. Step counter k runs 0..3.
  - Each step adds (acc * i_data[16k+15:16k]) << 16k into a product register.
  - After k=3, acc = product[63:0]. Next state is OUT if the latched last flag is set, otherwise ACC.
- OUT state:
  - o_valid=1, o_ready=0, o_result=acc.
  - o_result is held stable while i_ready is low.
  - On i_ready, acc is cleared to 0 and the next state is ACC.
- A packet that starts without LOAD uses acc=0 as its initial value.
- A single-beat packet is legal and yields that beat's own op result.
- Reset asserted in any state abandons the packet:
  - acc=0, state ACC, product and counter cleared.
  - With the macro, the carry flag is also cleared.

## Timing
- All outputs are registered. Values during reset and in the cycle after reset:
  - o_ready is 0 while i_rst_n is low and 1 in the first cycle after i_rst_n rises.
  - o_valid=0, o_result=0, o_carry=0.
- LOAD/PLUS/MINUS take 1 cycle. A beat accepted at cycle t updates acc at t+1.
- If that beat has i_last, o_valid rises at t+1.
- MUL accepted at t: MUL state occupies t+1..t+4, acc is updated at t+5, and o_ready (or o_valid if last) rises at t+5.
- Throughput: 1 beat/cycle for non-MUL ops. MUL costs 5 cycles per beat.
- Result handshake completes when o_valid and i_ready are both high. The next beat can be accepted in the following cycle.
- o_ready and o_valid are never high together.

## Configuration
- NUM_ACC_CARRY_EN defined:
  - Port o_carry exists. It is sticky within a packet, reported with o_result, and cleared when the result is accepted.
  - It sets on PLUS carry-out, on MINUS borrow (i_data > acc), and on MUL when any of product bits [127:64] are non-zero.
  - The product register widens to 128 bits.
- Not defined: no o_carry port, and the product register is 64 bits. Data path timing is identical either way.

## Structure
- Package num_pkg holds:
  - typedef enum logic [1:0] num_op_e {NUM_LOAD, NUM_PLUS, NUM_MINUS, NUM_MUL}.
  - localparam NUM_W=64, NUM_DIGIT_W=16, NUM_MUL_STEPS=4.
  - The state enum num_acc_state_e.
- One sub-module, num_mul_iter. It is the 4-step 64x16 shift-add multiplier:
  - Inputs: start, multiplicand, multiplier.
  - Outputs: done pulse and product. Product width depends on the macro.
- num_acc owns the FSM, the handshakes and the add/sub path.

## Test plan
- Reset then single beat: LOAD 5 with last=1, i_ready=1. Expect o_valid at t+1 with o_result=5. Next cycle o_ready=1.
- PLUS wrap: LOAD 0xFFFF_FFFF_FFFF_FFFF, then PLUS 2 with last. Expect result 1 and, with the macro, o_carry=1.
- MINUS underflow: LOAD 3, MINUS 5 last. Expect 0xFFFF_FFFF_FFFF_FFFE and o_carry=1.
- MUL latency and value: LOAD 0x1_0000_0001, MUL 0x1_0000_0003 last.
  - Expect o_ready low for 4 cycles and o_valid at t+5.
  - Expect result 0x4_0000_0003 and o_carry=1.
- Backpressure: hold i_ready=0 for 10 cycles in OUT. Expect o_result stable, o_ready=0 and no beats accepted. Then release and check acc clears: a following PLUS 7 last gives 7.
- Reset mid-MUL: assert i_rst_n=0 at k=2. Expect o_ready=0 while reset is held and o_ready=1 in the cycle after release, no o_valid, and the next LOAD 9 last gives 9.

Source files
------------

// File: rtl/num_acc_pkg.sv
// Shared types and constants for the num_acc fold unit.
// NUM_ACC_CARRY_EN widens the product to 128 bits so the overflow flag can be derived.
package num_pkg;

  localparam int unsigned NUM_W         = 64;
  localparam int unsigned NUM_DIGIT_W   = 16;
  localparam int unsigned NUM_MUL_STEPS = 4;

`ifdef NUM_ACC_CARRY_EN
  localparam int unsigned NUM_PROD_W = 2 * NUM_W;
`else
  localparam int unsigned NUM_PROD_W = NUM_W;
`endif

  typedef enum logic [1:0] {
    NUM_LOAD  = 2'd0,
    NUM_PLUS  = 2'd1,
    NUM_MINUS = 2'd2,
    NUM_MUL   = 2'd3
  } num_op_e;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_MUL = 2'd1,
    ST_OUT = 2'd2
  } num_acc_state_e;

endpackage

// File: rtl/num_acc_mul_iter.sv
// Iterative shift-add multiplier: one 64x16 partial product per cycle over 4 cycles.
// Product width follows NUM_ACC_CARRY_EN via num_pkg::NUM_PROD_W.
module num_mul_iter
  import num_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [NUM_W-1:0]      i_multiplicand,
  input  logic [NUM_W-1:0]      i_multiplier,
  output logic                  o_done,
  output logic [NUM_PROD_W-1:0] o_product
);

  localparam int unsigned K_W = $clog2(NUM_MUL_STEPS);

  logic [K_W-1:0]        r_k;
  logic                  r_busy;
  logic [NUM_W-1:0]      r_mcand;
  logic [NUM_W-1:0]      r_mplier;
  logic [NUM_PROD_W-1:0] r_prod;

  logic [NUM_DIGIT_W-1:0] w_digit;
  logic [NUM_PROD_W-1:0]  w_pp;
  logic [NUM_PROD_W-1:0]  w_sum;

  // Final step's sum is presented combinationally so the caller can commit it on the done edge.
  always_comb begin
    w_digit = r_mplier[r_k*NUM_DIGIT_W +: NUM_DIGIT_W];
    w_pp    = (NUM_PROD_W'(r_mcand) * NUM_PROD_W'(w_digit)) << (r_k * NUM_DIGIT_W);
    w_sum   = r_prod + w_pp;
  end

  assign o_done    = r_busy && (r_k == K_W'(NUM_MUL_STEPS - 1));
  assign o_product = w_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_start) begin
      r_k      <= '0;
      r_busy   <= 1'b1;
      r_mcand  <= i_multiplicand;
      r_mplier <= i_multiplier;
      r_prod   <= '0;
    end else if (r_busy) begin
      r_prod <= w_sum;
      r_k    <= r_k + K_W'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/num_acc.sv
// Streaming 64-bit fold unit: reduces a packet of LOAD/PLUS/MINUS/MUL beats to one result.
// NUM_ACC_CARRY_EN adds the sticky o_carry overflow flag.
module num_acc
  import num_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [NUM_W-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NUM_W-1:0] o_result
`ifdef NUM_ACC_CARRY_EN
  ,
  output logic             o_carry
`endif
);

  num_acc_state_e r_state, w_state_nxt;
  logic [NUM_W-1:0] r_acc, w_acc_nxt;
  logic r_last;
  logic r_ready;
  logic r_valid;

  logic w_accept;
  logic w_hs;
  logic w_mul_start;
  logic w_mul_done;
  logic [NUM_PROD_W-1:0] w_product;
  num_op_e w_op;

`ifdef NUM_ACC_CARRY_EN
  logic r_carry, w_carry_nxt, w_cy;
`endif

  assign w_op        = num_op_e'(i_op);
  assign w_accept    = i_valid && r_ready;
  assign w_mul_start = w_accept && (w_op == NUM_MUL);
  assign w_hs        = r_valid && i_ready;

  num_mul_iter u_mul (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (w_mul_start),
    .i_multiplicand (r_acc),
    .i_multiplier   (i_data),
    .o_done         (w_mul_done),
    .o_product      (w_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
`ifdef NUM_ACC_CARRY_EN
    w_carry_nxt = r_carry;
    w_cy        = 1'b0;
`endif
    unique case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          unique case (w_op)
            NUM_LOAD: w_acc_nxt = i_data;
            NUM_PLUS: begin
`ifdef NUM_ACC_CARRY_EN
              {w_cy, w_acc_nxt} = {1'b0, r_acc} + {1'b0, i_data};
              w_carry_nxt       = r_carry | w_cy;
`else
              w_acc_nxt = r_acc + i_data;
`endif
            end
            NUM_MINUS: begin
              w_acc_nxt = r_acc - i_data;
`ifdef NUM_ACC_CARRY_EN
              w_carry_nxt = r_carry | (i_data > r_acc);
`endif
            end
            NUM_MUL: w_state_nxt = ST_MUL;
            default: w_acc_nxt = r_acc;
          endcase
          if ((w_op != NUM_MUL) && i_last) w_state_nxt = ST_OUT;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_acc_nxt   = w_product[NUM_W-1:0];
`ifdef NUM_ACC_CARRY_EN
          w_carry_nxt = r_carry | (|w_product[NUM_PROD_W-1:NUM_W]);
`endif
          w_state_nxt = r_last ? ST_OUT : ST_ACC;
        end
      end
      ST_OUT: begin
        if (w_hs) begin
          w_acc_nxt   = '0;
`ifdef NUM_ACC_CARRY_EN
          w_carry_nxt = 1'b0;
`endif
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Handshake outputs are registered from the next state so o_ready stays low through reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
`ifdef NUM_ACC_CARRY_EN
      r_carry <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ready <= (w_state_nxt == ST_ACC);
      r_valid <= (w_state_nxt == ST_OUT);
      if (w_mul_start) r_last <= i_last;
`ifdef NUM_ACC_CARRY_EN
      r_carry <= w_carry_nxt;
`endif
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_result = r_acc;
`ifdef NUM_ACC_CARRY_EN
  assign o_carry  = r_carry;
`endif

endmodule

// File: tb/tb_num_acc.sv
// Self-checking bench for num_acc: directed scenarios plus randomized packets vs a packet-level model.
// Carry checks are compiled in when NUM_ACC_CARRY_EN is defined.
module tb_num_acc;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [63:0] i_data;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;
`ifdef NUM_ACC_CARRY_EN
  logic        o_carry;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0]  pk_op[$];
  logic [63:0] pk_data[$];

  always #5 i_clk = ~i_clk;

  num_acc dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
`ifdef NUM_ACC_CARRY_EN
    ,
    .o_carry  (o_carry)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Packet-level reference: wrap-around arithmetic on the whole beat list, 128-bit for overflow.
  function automatic void model(output logic [63:0] res, output logic cy);
    logic [127:0] wide;
    res = '0;
    cy  = 1'b0;
    for (int i = 0; i < pk_op.size(); i++) begin
      case (pk_op[i])
        2'd0: res = pk_data[i];
        2'd1: begin
          wide = {64'd0, res} + {64'd0, pk_data[i]};
          cy   = cy | (wide[127:64] != 0);
          res  = wide[63:0];
        end
        2'd2: begin
          cy  = cy | (pk_data[i] > res);
          res = res - pk_data[i];
        end
        default: begin
          wide = {64'd0, res} * {64'd0, pk_data[i]};
          cy   = cy | (wide[127:64] != 0);
          res  = wide[63:0];
        end
      endcase
    end
  endfunction

  task automatic send_beat(input logic [1:0] op, input logic [63:0] d, input logic last);
    logic rb;
    int unsigned n;
    n       = 0;
    i_valid = 1'b1;
    i_op    = op;
    i_data  = d;
    i_last  = last;
    forever begin
      rb = o_ready;
      checks++;
      if (o_ready && o_valid) begin
        errors++;
        $display("FAIL ready_valid_excl got ready=%b valid=%b exp not both", o_ready, o_valid);
      end
      tick();
      if (rb) break;
      n++;
      if (n > 20) begin
        errors++;
        $display("FAIL beat_accept_timeout got o_ready=0 exp 1");
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic collect(input string name, input int unsigned stall,
                         input logic [63:0] exp, input logic expc);
    int unsigned n;
    n = 0;
    while (o_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got %b exp 1", name, o_valid);
    end
    repeat (stall) tick();
    checks++;
    if (o_result !== exp) begin
      errors++;
      $display("FAIL %s_result got %h exp %h", name, o_result, exp);
    end
`ifdef NUM_ACC_CARRY_EN
    checks++;
    if (o_carry !== expc) begin
      errors++;
      $display("FAIL %s_carry got %b exp %b", name, o_carry, expc);
    end
`endif
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_op    = 2'd0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({o_ready, o_valid} !== 2'b00 || o_result !== 64'd0) begin
        errors++;
        $display("FAIL reset_outputs got rdy=%b vld=%b res=%h exp 0 0 0", o_ready, o_valid, o_result);
      end
`ifdef NUM_ACC_CARRY_EN
      checks++;
      if (o_carry !== 1'b0) begin
        errors++;
        $display("FAIL reset_carry got %b exp 0", o_carry);
      end
`endif
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b exp 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_single_beat();
    i_ready = 1'b1;
    send_beat(2'd0, 64'd5, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_result !== 64'd5) begin
      errors++;
      $display("FAIL single_beat got vld=%b res=%h exp 1 5", o_valid, o_result);
    end
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after got rdy=%b vld=%b exp 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_plus_wrap();
    send_beat(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat(2'd1, 64'd2, 1'b1);
    collect("plus_wrap", 0, 64'd1, 1'b1);
  endtask

  task automatic test_minus_under();
    send_beat(2'd0, 64'd3, 1'b0);
    send_beat(2'd2, 64'd5, 1'b1);
    collect("minus_under", 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
  endtask

  task automatic test_mul();
    send_beat(2'd0, 64'h1_0000_0001, 1'b0);
    send_beat(2'd3, 64'h1_0000_0003, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_ready, o_valid} !== 2'b00) begin
        errors++;
        $display("FAIL mul_busy_%0d got rdy=%b vld=%b exp 0 0", i, o_ready, o_valid);
      end
      tick();
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul_latency got vld=%b exp 1", o_valid);
    end
    collect("mul", 0, 64'h4_0000_0003, 1'b1);
  endtask

  task automatic test_backpressure();
    send_beat(2'd0, 64'd11, 1'b0);
    send_beat(2'd1, 64'd4, 1'b1);
    i_valid = 1'b1;
    i_op    = 2'd0;
    i_data  = 64'd99;
    i_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 64'd15) begin
        errors++;
        $display("FAIL bp_hold_%0d got rdy=%b vld=%b res=%h exp 0 1 f", i, o_ready, o_valid, o_result);
      end
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b exp 1 0", o_ready, o_valid);
    end
    send_beat(2'd1, 64'd7, 1'b1);
    collect("bp_after", 0, 64'd7, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    send_beat(2'd0, 64'h1234, 1'b0);
    send_beat(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    tick();
    i_rst_n = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if ({o_ready, o_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mul_hold got rdy=%b vld=%b exp 0 0", o_ready, o_valid);
      end
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 64'd0) begin
      errors++;
      $display("FAIL rst_mul_release got rdy=%b vld=%b res=%h exp 1 0 0", o_ready, o_valid, o_result);
    end
    send_beat(2'd0, 64'd9, 1'b1);
    collect("rst_mul_after", 0, 64'd9, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] exp;
    logic        expc;
    int unsigned n;
    for (int p = 0; p < 40; p++) begin
      pk_op.delete();
      pk_data.delete();
      n = $urandom_range(1, 6);
      for (int b = 0; b < int'(n); b++) begin
        pk_op.push_back(2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) pk_data.push_back(64'($urandom_range(0, 20)));
        else pk_data.push_back({$urandom, $urandom});
      end
      model(exp, expc);
      for (int b = 0; b < int'(n); b++)
        send_beat(pk_op[b], pk_data[b], (b == int'(n) - 1));
      collect($sformatf("rand%0d", p), $urandom_range(0, 3), exp, expc);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_plus_wrap();
    test_minus_under();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
